// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/branch sequencer and its datapath.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_BRANCH = 3'd4
  } fetch_state_e;

  localparam logic [1:0] COND_ZERO    = 2'b00;
  localparam logic [1:0] COND_NONZERO = 2'b01;
  localparam logic [1:0] COND_POS     = 2'b10;
  localparam logic [1:0] COND_NEG     = 2'b11;

  // Instruction word field positions
  localparam int IR_COND_HI = 20;
  localparam int IR_COND_LO = 19;
  localparam int IR_OFS_HI  = 18;
  localparam int IR_OFS_W   = 19;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition test on a register value; purely combinational so the
// datapath CON flop can reuse it.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [1:0]  cond,
  input  logic [31:0] value,
  output logic        taken
);

  // Decode the two-bit condition against the sign and zero-ness of value
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ZERO:    taken = (value == 32'd0);
      COND_NONZERO: taken = (value != 32'd0);
      COND_POS:     taken = !value[31] && (value != 32'd0);
      COND_NEG:     taken = value[31];
      default:      taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_branch_sequencer.sv
// Fetch-side sequencer: fetches one word at the PC, holds it for the decoder
// and resolves conditional branches by steering the PC control inputs.
//
//   state  | meaning
//   IDLE   | waiting for start
//   ADDR   | address registered, PC increments this cycle
//   WAIT   | read outstanding, bounded by WAIT_MAX cycles
//   HOLD   | ir valid, waiting for ack or branch evaluation
//   BRANCH | drive CON/enable from latched condition, pulse br_done
module fetch_branch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int WAIT_MAX = 15
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              start,
  input  logic [31:0]       pc_value,
  output logic              pc_enable,
  output logic              pc_inc,
  output logic              pc_con,
  output logic [31:0]       pc_offset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ack,
  input  logic              br_eval,
  input  logic [31:0]       br_reg_value,
  output logic              br_done,
  output logic              busy,
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(WAIT_MAX) + 1;

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              con_q, con_d;
  logic              err_q, err_d;
  logic              cond_taken;

  // Only the word-address bits of the PC reach memory
  logic unused_pc_hi;
  assign unused_pc_hi = ^pc_value[31:ADDR_W];

  branch_cond_eval u_cond (
    .cond  (ir_q[IR_COND_HI:IR_COND_LO]),
    .value (br_reg_value),
    .taken (cond_taken)
  );

  // State and datapath registers
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ir_q    <= '0;
      addr_q  <= '0;
      con_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      con_q   <= con_d;
      err_q   <= err_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
    con_d   = con_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR;
          addr_d  = pc_value[ADDR_W-1:0];
          err_d   = 1'b0;
        end
      end
      ST_ADDR: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        // A branch request implies the ack, so it takes priority
        if (br_eval) begin
          con_d   = cond_taken;
          state_d = ST_BRANCH;
        end else if (ir_ack) begin
          state_d = ST_IDLE;
        end
      end
      ST_BRANCH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only; enable never fires without
  // either IncPC (ADDR) or CON (taken branch)
  always_comb begin
    pc_enable = (state_q == ST_ADDR) || ((state_q == ST_BRANCH) && con_q);
    pc_inc    = (state_q == ST_ADDR);
    pc_con    = (state_q == ST_BRANCH) && con_q;
    mem_rd    = (state_q == ST_WAIT);
    ir_valid  = (state_q == ST_HOLD);
    br_done   = (state_q == ST_BRANCH);
    busy      = (state_q != ST_IDLE);
  end

  assign pc_offset = {{(32 - IR_OFS_W){ir_q[IR_OFS_HI]}}, ir_q[IR_OFS_HI:0]};
  assign mem_addr  = addr_q;
  assign ir        = ir_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_branch_sequencer.sv
// Directed bench for fetch_branch_sequencer: fetch latency, stalls, timeout,
// branch conditions, priority of br_eval over ir_ack, async reset.
module tb_fetch_branch_sequencer;

  localparam int ADDR_W = 9;

  logic              clock = 1'b0;
  logic              clear_n;
  logic              start;
  logic [31:0]       pc_value;
  logic              pc_enable, pc_inc, pc_con;
  logic [31:0]       pc_offset;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [31:0]       ir;
  logic              ir_valid;
  logic              ir_ack;
  logic              br_eval;
  logic [31:0]       br_reg_value;
  logic              br_done, busy, fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_branch_sequencer #(.ADDR_W(ADDR_W), .WAIT_MAX(15)) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .start        (start),
    .pc_value     (pc_value),
    .pc_enable    (pc_enable),
    .pc_inc       (pc_inc),
    .pc_con       (pc_con),
    .pc_offset    (pc_offset),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .ir_ack       (ir_ack),
    .br_eval      (br_eval),
    .br_reg_value (br_reg_value),
    .br_done      (br_done),
    .busy         (busy),
    .fetch_err    (fetch_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All outputs that must be zero after reset, packed for one compare
  function automatic logic [31:0] out_flags();
    return {24'd0, busy, mem_rd, pc_enable, pc_inc, pc_con, ir_valid, br_done, fetch_err};
  endfunction

  // Runs a fetch from the current negedge until HOLD or a return to IDLE.
  // Memory answers after 'delay' stalled read cycles.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input int delay,
                          input bit keep_start, output int lat, output int rd,
                          output int en, output int inc, output int con,
                          output logic [31:0] addr_seen);
    bit fin;
    fin = 0; lat = 0; rd = 0; en = 0; inc = 0; con = 0; addr_seen = '1;
    pc_value = pc;
    start    = 1'b1;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (!keep_start) start = 1'b0;
      if (pc_enable) begin en++; addr_seen = 32'(mem_addr); end
      if (pc_inc) inc++;
      if (pc_con) con++;
      if (mem_rd) begin
        rd++;
        mem_ready = (rd > delay);
        mem_rdata = data;
      end else begin
        mem_ready = 1'b0;
      end
      if (ir_valid || !busy) fin = 1;
    end
    mem_ready = 1'b0;
    chk("fetch_bound", 32'(fin), 32'd1);
  endtask

  // Issues br_eval (optionally with ir_ack) from HOLD and checks BRANCH and the return to IDLE
  task automatic do_branch(input string tag, input logic [31:0] regv, input bit with_ack,
                           input bit exp_taken);
    br_reg_value = regv;
    br_eval      = 1'b1;
    ir_ack       = with_ack;
    @(posedge clock);
    @(negedge clock);
    br_eval = 1'b0;
    ir_ack  = 1'b0;
    chk({tag, "_br_done"}, 32'(br_done), 32'd1);
    chk({tag, "_pc_enable"}, 32'(pc_enable), 32'(exp_taken));
    chk({tag, "_pc_con"}, 32'(pc_con), 32'(exp_taken));
    chk({tag, "_pc_inc"}, 32'(pc_inc), 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_idle"}, {29'd0, busy, br_done, pc_enable}, 32'd0);
  endtask

  task automatic do_ack();
    ir_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ir_ack = 1'b0;
    chk("ack_idle", {30'd0, busy, ir_valid}, 32'd0);
  endtask

  int          lat, rd, en, inc, con;
  logic [31:0] addr_seen;

  initial begin
    clear_n      = 1'b0;
    start        = 1'b0;
    pc_value     = '0;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    ir_ack       = 1'b0;
    br_eval      = 1'b0;
    br_reg_value = '0;
    repeat (2) @(negedge clock);
    chk("reset_flags", out_flags(), 32'd0);
    chk("reset_ir", ir, 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    clear_n = 1'b1;
    @(negedge clock);

    // Minimum-latency fetch
    do_fetch(32'h5, 32'h1234_5678, 0, 0, lat, rd, en, inc, con, addr_seen);
    chk("f1_latency", 32'(lat), 32'd3);
    chk("f1_mem_rd_cycles", 32'(rd), 32'd1);
    chk("f1_en_cycles", 32'(en), 32'd1);
    chk("f1_inc_cycles", 32'(inc), 32'd1);
    chk("f1_con_cycles", 32'(con), 32'd0);
    chk("f1_mem_addr", addr_seen, 32'd5);
    chk("f1_ir", ir, 32'h1234_5678);
    chk("f1_ir_valid", 32'(ir_valid), 32'd1);
    do_ack();

    // Four stalled cycles, address truncated to the word-address width
    do_fetch(32'hABCD_E3FF, 32'h0007_FFFD, 4, 0, lat, rd, en, inc, con, addr_seen);
    chk("f2_latency", 32'(lat), 32'd7);
    chk("f2_mem_rd_cycles", 32'(rd), 32'd5);
    chk("f2_mem_addr", addr_seen, 32'h1FF);
    chk("f2_pc_offset", pc_offset, 32'hFFFF_FFFD);
    do_branch("zero_taken", 32'd0, 0, 1);

    // Positive condition: negative and zero values are both not taken
    do_fetch(32'h10, 32'h0010_0010, 0, 0, lat, rd, en, inc, con, addr_seen);
    chk("f3_pc_offset", pc_offset, 32'h0000_0010);
    do_branch("pos_neg_val", 32'h8000_0000, 0, 0);
    do_fetch(32'h11, 32'h0010_0010, 0, 0, lat, rd, en, inc, con, addr_seen);
    do_branch("pos_zero_val", 32'd0, 0, 0);

    // Memory never answers: timeout after WAIT_MAX read cycles, ir untouched
    do_fetch(32'h20, 32'hDEAD_BEEF, 99, 0, lat, rd, en, inc, con, addr_seen);
    chk("to_mem_rd_cycles", 32'(rd), 32'd15);
    chk("to_fetch_err", 32'(fetch_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_ir_valid", 32'(ir_valid), 32'd0);
    chk("to_ir_kept", ir, 32'h0010_0010);

    // Next fetch clears the sticky error; nonzero condition taken
    do_fetch(32'h21, 32'h0008_0001, 0, 0, lat, rd, en, inc, con, addr_seen);
    chk("f5_fetch_err_clr", 32'(fetch_err), 32'd0);
    do_branch("nonzero_taken", 32'h0000_0040, 0, 1);

    // start held high throughout; br_eval with ir_ack takes the branch path
    do_fetch(32'h30, 32'h0018_0004, 1, 1, lat, rd, en, inc, con, addr_seen);
    chk("f6_latency", 32'(lat), 32'd4);
    chk("f6_en_cycles", 32'(en), 32'd1);
    @(posedge clock);
    @(negedge clock);
    chk("f6_hold_with_start", {30'd0, busy, ir_valid}, 32'd3);
    do_branch("neg_ack_taken", 32'hFFFF_FFFF, 1, 1);
    @(posedge clock);
    @(negedge clock);
    chk("b2b_addr_state", {30'd0, pc_enable, pc_inc}, 32'd3);

    // Reset landing in ADDR: everything drops immediately, no further enable
    clear_n = 1'b0;
    #1;
    chk("rst_addr_flags", out_flags(), 32'd0);
    chk("rst_addr_ir", ir, 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("rst_addr_after", out_flags(), 32'd0);
    start   = 1'b0;
    clear_n = 1'b1;
    @(negedge clock);

    // Reset landing in WAIT
    pc_value = 32'h44;
    start    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("rw_in_wait", 32'(mem_rd), 32'd1);
    clear_n = 1'b0;
    #1;
    chk("rst_wait_flags", out_flags(), 32'd0);
    chk("rst_wait_addr", 32'(mem_addr), 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);

    // Normal fetch after release
    do_fetch(32'h7, 32'hCAFE_F00D, 0, 0, lat, rd, en, inc, con, addr_seen);
    chk("f7_latency", 32'(lat), 32'd3);
    chk("f7_mem_addr", addr_seen, 32'd7);
    chk("f7_ir", ir, 32'hCAFE_F00D);
    do_ack();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
